// File: rtl/capture_pingpong_ctrl.sv
// rtl/capture_pingpong_ctrl.sv - write-side sequencer for a 2-bank ping-pong capture RAM
// Fills the active bank with decimated samples and hands full banks to the reader over a 4-phase req/ack.
module capture_pingpong_ctrl #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 10,
  parameter int DECIM_W = 8,
  parameter int OVF_W   = 16
) (
  input  logic               clkout_3,
  input  logic               rst,
  input  logic               pll_lock,
  input  logic               start,
  input  logic               stop,
  input  logic [DECIM_W-1:0] decim,
  input  logic [DATA_W-1:0]  data_in,
  input  logic               ack_async,
  output logic               wr_en,
  output logic [ADDR_W:0]    wr_addr,
  output logic [DATA_W-1:0]  wr_data,
  output logic               req,
  output logic               rd_bank,
  output logic [OVF_W-1:0]   ovf_cnt,
  output logic               busy,
  output logic               lock_err
);
  typedef enum logic [1:0] {IDLE, FILL, STALL} fill_state_t;
  typedef enum logic [1:0] {HS_IDLE, HS_REQ, HS_REL} hs_state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  fill_state_t        state_q, state_d;
  hs_state_t          hs_q, hs_d;
  logic               lock_m_q, lock_s_q, ack_m_q, ack_s_q;
  logic               bank_q, bank_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DECIM_W-1:0] dcnt_q, dcnt_d, decim_l_q, decim_l_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W:0]    wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;
  logic               req_q, req_d, rd_bank_q, rd_bank_d;
  logic [OVF_W-1:0]   ovf_q, ovf_d;
  logic               busy_q, busy_d, lock_err_q, lock_err_d;
  logic               accept, handoff;

  assign accept = (dcnt_q == decim_l_q);

  always_comb begin
    state_d    = state_q;
    hs_d       = hs_q;
    bank_d     = bank_q;
    addr_d     = addr_q;
    dcnt_d     = dcnt_q;
    decim_l_d  = decim_l_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    req_d      = req_q;
    rd_bank_d  = rd_bank_q;
    ovf_d      = ovf_q;
    lock_err_d = lock_err_q;
    handoff    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !stop && lock_s_q) begin
          state_d    = FILL;
          bank_d     = 1'b0;
          addr_d     = '0;
          dcnt_d     = '0;
          decim_l_d  = decim;
          ovf_d      = '0;
          lock_err_d = 1'b0;
        end
      end
      FILL, STALL: begin
        // Abort wins over any write or handoff due in the same cycle; the partial bank is dropped.
        if (stop || !lock_s_q) begin
          state_d = IDLE;
          if (!lock_s_q) lock_err_d = 1'b1;
        end else begin
          dcnt_d = accept ? '0 : dcnt_q + 1'b1;
          if (state_q == FILL) begin
            if (accept) begin
              wr_en_d   = 1'b1;
              wr_addr_d = {bank_q, addr_q};
              wr_data_d = data_in;
              if (addr_q == ADDR_MAX) begin
                if (hs_q == HS_IDLE) handoff = 1'b1;
                else                 state_d = STALL;
              end else begin
                addr_d = addr_q + 1'b1;
              end
            end
          end else begin
            if (accept && ovf_q != '1) ovf_d = ovf_q + 1'b1;
            if (hs_q == HS_IDLE) begin
              handoff = 1'b1;
              state_d = FILL;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (handoff) begin
      rd_bank_d = bank_q;
      req_d     = 1'b1;
      bank_d    = ~bank_q;
      addr_d    = '0;
    end

    // handoff only fires from HS_IDLE, so it never collides with the req release below
    case (hs_q)
      HS_IDLE: if (handoff) hs_d = HS_REQ;
      HS_REQ: begin
        if (ack_s_q) begin
          hs_d  = HS_REL;
          req_d = 1'b0;
        end
      end
      HS_REL:  if (!ack_s_q) hs_d = HS_IDLE;
      default: hs_d = HS_IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clkout_3 or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      hs_q       <= HS_IDLE;
      lock_m_q   <= 1'b0;
      lock_s_q   <= 1'b0;
      ack_m_q    <= 1'b0;
      ack_s_q    <= 1'b0;
      bank_q     <= 1'b0;
      addr_q     <= '0;
      dcnt_q     <= '0;
      decim_l_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      req_q      <= 1'b0;
      rd_bank_q  <= 1'b0;
      ovf_q      <= '0;
      busy_q     <= 1'b0;
      lock_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hs_q       <= hs_d;
      lock_m_q   <= pll_lock;
      lock_s_q   <= lock_m_q;
      ack_m_q    <= ack_async;
      ack_s_q    <= ack_m_q;
      bank_q     <= bank_d;
      addr_q     <= addr_d;
      dcnt_q     <= dcnt_d;
      decim_l_q  <= decim_l_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      req_q      <= req_d;
      rd_bank_q  <= rd_bank_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      lock_err_q <= lock_err_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign req      = req_q;
  assign rd_bank  = rd_bank_q;
  assign ovf_cnt  = ovf_q;
  assign busy     = busy_q;
  assign lock_err = lock_err_q;
endmodule

// File: tb/tb_capture_pingpong_ctrl.sv
// tb/tb_capture_pingpong_ctrl.sv - randomized directed bench for capture_pingpong_ctrl
// Expected writes follow from arithmetic: write k lands at start+(k+1)*(decim+1), address k mod 2*DEPTH.
module tb_capture_pingpong_ctrl;
  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 10;
  localparam int DECIM_W = 8;
  localparam int OVF_W   = 12;
  localparam int DEPTH   = 1 << ADDR_W;
  localparam int OVF_MAX = (1 << OVF_W) - 1;

  logic               clkout_3 = 1'b0;
  logic               rst = 1'b0, pll_lock = 1'b1, start = 1'b0, stop = 1'b0, ack_async = 1'b0;
  logic [DECIM_W-1:0] decim = '0;
  logic [DATA_W-1:0]  data_in = '0;
  logic               wr_en, req, rd_bank, busy, lock_err;
  logic [ADDR_W:0]    wr_addr;
  logic [DATA_W-1:0]  wr_data;
  logic [OVF_W-1:0]   ovf_cnt;

  typedef struct { int c; int addr; int data; int din; } wr_t;
  wr_t wlog[$];
  int  req_rise[$];
  int  req_rb[$];
  int  checks = 0, errors = 0, cyc = 0, s_cyc = 0;
  int  ack_edge_c = 0, req_fall_c = 0;
  logic reader_auto = 1'b0, ack_man = 1'b0;
  int  reader_delay = 100;

  always #5 clkout_3 = ~clkout_3;

  capture_pingpong_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DECIM_W(DECIM_W), .OVF_W(OVF_W)) dut (
    .clkout_3(clkout_3), .rst(rst), .pll_lock(pll_lock), .start(start), .stop(stop),
    .decim(decim), .data_in(data_in), .ack_async(ack_async), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .req(req), .rd_bank(rd_bank), .ovf_cnt(ovf_cnt), .busy(busy), .lock_err(lock_err)
  );

  always @(posedge clkout_3) begin : mon
    logic [DATA_W-1:0] din_e;
    logic ack_e, req_prev, ack_prev;
    wr_t e;
    cyc++;
    din_e = data_in;
    ack_e = ack_async;
    if (ack_e && !ack_prev) ack_edge_c = cyc;
    ack_prev = ack_e;
    #1;
    if (wr_en) begin
      e.c = cyc; e.addr = int'(wr_addr); e.data = int'(wr_data); e.din = int'(din_e);
      wlog.push_back(e);
    end
    if (req && !req_prev) begin req_rise.push_back(cyc); req_rb.push_back(int'(rd_bank)); end
    if (!req && req_prev) req_fall_c = cyc;
    req_prev = req;
  end

  initial begin : reader
    int n;
    n = 0;
    forever begin
      @(negedge clkout_3);
      if (!reader_auto) begin
        ack_async = ack_man;
        n = 0;
      end else if (req && !ack_async) begin
        if (n >= reader_delay) begin ack_async = 1'b1; n = 0; end
        else n++;
      end else if (!req && ack_async) begin
        ack_async = 1'b0;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clkout_3);
      data_in = DATA_W'($urandom);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_start(input int d);
    decim = DECIM_W'(d);
    start = 1'b1;
    tick();
    start = 1'b0;
    s_cyc = cyc;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick(2);
  endtask

  task automatic wait_writes(input string tag, input int n, input int budget);
    int i;
    i = 0;
    while (wlog.size() < n && i < budget) begin tick(); i++; end
    check(tag, 32'(wlog.size() >= n), 1);
  endtask

  task automatic wait_req_low(input string tag, input int budget);
    int i;
    i = 0;
    while (req && i < budget) begin tick(); i++; end
    check(tag, 32'(req), 0);
  endtask

  task automatic wait_hs(input string tag);
    int i;
    i = 0;
    while ((req || ack_async) && i < 1000) begin tick(); i++; end
    tick(4);
    check(tag, 32'(req | ack_async), 0);
  endtask

  task automatic check_stream(input string tag, input int s, input int d, input int n);
    int bad_a, bad_d, bad_c;
    bad_a = 0; bad_d = 0; bad_c = 0;
    for (int k = 0; k < n; k++) begin
      if (wlog[k].addr != k % (2 * DEPTH)) bad_a++;
      if (wlog[k].data != wlog[k].din) bad_d++;
      if (wlog[k].c != s + (k + 1) * (d + 1)) bad_c++;
    end
    check({tag, "_addr_errs"}, bad_a, 0);
    check({tag, "_data_errs"}, bad_d, 0);
    check({tag, "_timing_errs"}, bad_c, 0);
  endtask

  initial begin : main
    int n, last, d, cnt;
    tick(3);
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    check("rst_req", 32'(req), 0);
    check("rst_rd_bank", 32'(rd_bank), 0);
    check("rst_ovf", 32'(ovf_cnt), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_lock_err", 32'(lock_err), 0);
    rst = 1'b1;
    tick(3);

    // Throughput with a reader that acks 100 cycles after each req
    reader_auto = 1'b1;
    wlog.delete(); req_rise.delete(); req_rb.delete();
    do_start(0);
    check("t2_busy", 32'(busy), 1);
    wait_writes("t2_wait", 2100, 2300);
    check_stream("t2", s_cyc, 0, 2100);
    check("t2_req_count", req_rise.size(), 2);
    check("t2_req0_cycle", req_rise[0], wlog[DEPTH-1].c);
    check("t2_req0_bank", req_rb[0], 0);
    check("t2_req1_cycle", req_rise[1], wlog[2*DEPTH-1].c);
    check("t2_req1_bank", req_rb[1], 1);
    do_stop();
    check("t2_stop_busy", 32'(busy), 0);
    n = wlog.size();
    tick(10);
    check("t2_no_wr_after_stop", wlog.size(), n);
    wait_hs("t2_hs_drain");

    // Decimation 3, with decim scrambled mid-capture
    wlog.delete();
    do_start(3);
    decim = DECIM_W'($urandom);
    tick(4100);
    cnt = 0;
    foreach (wlog[k]) if (wlog[k].c <= s_cyc + 4096) cnt++;
    check("t3_writes_in_4096", cnt, 1024);
    check_stream("t3", s_cyc, 3, 1024);
    do_stop();
    wait_hs("t3_hs_drain");

    // Random decimation ratio
    d = $urandom_range(7, 1);
    wlog.delete();
    do_start(d);
    wait_writes("t3b_wait", 300, 300 * (d + 1) + 20);
    check_stream("t3b", s_cyc, d, 300);
    do_stop();
    wait_hs("t3b_hs_drain");

    // Overflow: reader never acks
    reader_auto = 1'b0;
    ack_man = 1'b0;
    wlog.delete();
    do_start(0);
    wait_writes("t4_wait", 2 * DEPTH, 2 * DEPTH + 100);
    tick(20);
    check("t4_writes_stop", wlog.size(), 2 * DEPTH);
    check_stream("t4", s_cyc, 0, 2 * DEPTH);
    last = wlog[2*DEPTH-1].c;
    check("t4_busy_stall", 32'(busy), 1);
    check("t4_ovf_run", 32'(ovf_cnt), (cyc - last) < OVF_MAX ? cyc - last : OVF_MAX);
    tick(OVF_MAX + 10);
    check("t4_ovf_sat", 32'(ovf_cnt), OVF_MAX);
    check("t4_req_held", 32'(req), 1);
    check("t4_rd_bank0", 32'(rd_bank), 0);
    ack_man = 1'b1;
    wait_req_low("t4_req_release", 20);
    ack_man = 1'b0;
    wait_writes("t4_resume", 2 * DEPTH + 1, 30);
    check("t4_resume_addr", wlog[2*DEPTH].addr, 0);
    check("t4_resume_req", 32'(req), 1);
    check("t4_resume_rd_bank", 32'(rd_bank), 1);
    check("t4_ovf_hold", 32'(ovf_cnt), OVF_MAX);
    do_stop();
    ack_man = 1'b1;
    wait_req_low("t4_cleanup_req", 20);
    ack_man = 1'b0;
    tick(6);

    // Lock loss mid-bank
    reader_auto = 1'b1;
    wlog.delete();
    do_start(0);
    check("t5_ovf_cleared", 32'(ovf_cnt), 0);
    wait_writes("t5_wait", 500, 600);
    pll_lock = 1'b0;
    tick(3);
    check("t5_wr_en_off", 32'(wr_en), 0);
    check("t5_lock_err", 32'(lock_err), 1);
    check("t5_idle", 32'(busy), 0);
    check("t5_write_total", wlog.size(), 502);
    pll_lock = 1'b1;
    tick(3);
    wlog.delete();
    do_start(0);
    check("t5_lock_err_clr", 32'(lock_err), 0);
    check("t5_ovf_zero", 32'(ovf_cnt), 0);
    wait_writes("t5b_wait", 8, 20);
    check_stream("t5b", s_cyc, 0, 8);
    do_stop();
    wait_hs("t5_hs_drain");

    // start/stop collision, then stop with a handoff outstanding
    reader_auto = 1'b0;
    ack_man = 1'b0;
    wlog.delete();
    decim = '0;
    start = 1'b1;
    stop = 1'b1;
    tick(4);
    start = 1'b0;
    stop = 1'b0;
    tick(2);
    check("t6_collide_idle", 32'(busy), 0);
    check("t6_collide_no_wr", wlog.size(), 0);
    do_start(0);
    wait_writes("t6_wait", 1500, 1600);
    do_stop();
    check("t6_stop_idle", 32'(busy), 0);
    check("t6_req_kept", 32'(req), 1);
    check("t6_rd_bank", 32'(rd_bank), 0);
    n = wlog.size();
    ack_man = 1'b1;
    wait_req_low("t6_req_fall", 20);
    check("t6_req_fall_latency", req_fall_c - ack_edge_c, 2);
    ack_man = 1'b0;
    tick(6);
    check("t6_no_wr", wlog.size(), n);

    // Async reset mid-FILL with req high
    wlog.delete();
    do_start(0);
    wait_writes("t1_wait", 1100, 1200);
    check("t1_req_before", 32'(req), 1);
    #2 rst = 1'b0;
    #1;
    check("t1_wr_en", 32'(wr_en), 0);
    check("t1_wr_addr", 32'(wr_addr), 0);
    check("t1_wr_data", 32'(wr_data), 0);
    check("t1_req", 32'(req), 0);
    check("t1_busy", 32'(busy), 0);
    check("t1_ovf", 32'(ovf_cnt), 0);
    tick();
    rst = 1'b1;
    ack_man = 1'b0;
    wlog.delete();
    tick(10);
    check("t1_post_no_wr", wlog.size(), 0);
    check("t1_post_idle", 32'(busy), 0);
    check("t1_post_req", 32'(req), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
